// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg
// Shared types and constants for the two-port RAM arbiter.
// Revision: 1.0
// ============================================================================
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 11;
    localparam int MEM_DATA_W = 16;

    localparam logic P_FETCH = 1'b0;
    localparam logic P_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// rr_pick2
// Combinational two-way picker: round-robin against the last winner, or
// fixed priority to port 0 when i_fixed is set.
// Revision: 1.0
// ============================================================================
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_fixed,
    output logic       o_winner,
    output logic       o_valid
);

    always_comb begin
        o_valid  = |i_req;
        o_winner = P_FETCH;
        if (i_req == 2'b10) begin
            o_winner = P_DATA;
        end else if (i_req == 2'b11 && !i_fixed) begin
            o_winner = ~i_last;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter
// Two-requester arbiter/sequencer in front of a registered-read RAM.
// Revision: 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_write,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,

    output logic              busy
);

    arb_state_t        r_state;
    logic              r_last;
    logic              r_owner;
    logic [1:0]        r_gnt;
    logic [1:0]        r_rvalid;
    logic              r_mem_write;
    logic              r_mem_read;
    logic              r_busy;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_data_in;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;

    logic [1:0]        w_req;
    logic              w_fixed;
    logic              w_winner;
    logic              w_valid;
    logic              w_write;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    assign w_req   = {p1_req, p0_req};
    assign w_fixed = (FIXED_PRIO != 0);

    rr_pick2 u_pick (
        .i_req    (w_req),
        .i_last   (r_last),
        .i_fixed  (w_fixed),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    assign w_write = (w_winner == P_DATA) ? p1_write : p0_write;
    assign w_addr  = (w_winner == P_DATA) ? p1_addr  : p0_addr;
    assign w_wdata = (w_winner == P_DATA) ? p1_wdata : p0_wdata;

    // Pulses (gnt, strobes, rvalid) default low every cycle; only the state
    // that owns them raises them for the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last        <= P_DATA;
            r_owner       <= P_FETCH;
            r_gnt         <= 2'b00;
            r_rvalid      <= 2'b00;
            r_mem_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_busy        <= 1'b0;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
            r_p0_rdata    <= '0;
            r_p1_rdata    <= '0;
        end else begin
            r_gnt       <= 2'b00;
            r_rvalid    <= 2'b00;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_owner       <= w_winner;
                        r_last        <= w_winner;
                        r_mem_address <= w_addr;
                        r_mem_data_in <= w_wdata;
                        r_mem_write   <= w_write;
                        r_mem_read    <= ~w_write;
                        r_gnt         <= (w_winner == P_DATA) ? 2'b10 : 2'b01;
                        r_busy        <= 1'b1;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The write strobe is still high here, so it doubles as the latched direction.
                    if (r_mem_write) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_owner == P_DATA) begin
                        r_p1_rdata <= mem_data_out;
                        r_rvalid   <= 2'b10;
                    end else begin
                        r_p0_rdata <= mem_data_out;
                        r_rvalid   <= 2'b01;
                    end
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign p0_gnt      = r_gnt[P_FETCH];
    assign p1_gnt      = r_gnt[P_DATA];
    assign p0_rvalid   = r_rvalid[P_FETCH];
    assign p1_rvalid   = r_rvalid[P_DATA];
    assign p0_rdata    = r_p0_rdata;
    assign p1_rdata    = r_p1_rdata;
    assign mem_write   = r_mem_write;
    assign mem_read    = r_mem_read;
    assign mem_address = r_mem_address;
    assign mem_data_in = r_mem_data_in;
    assign busy        = r_busy;

endmodule
`default_nettype wire
